opb_register_ppc2simulink_strobe: RTL and testbench

OPB slave register in the reverse direction of the simulink2ppc status registers: the PowerPC writes a 32-bit word over OPB, and the block presents it to fabric user logic on user_data_out with a one-cycle update strobe. It also keeps a readback copy and a write counter at a second word, so software can confirm delivery. Everything runs in one clock domain (OPB_Clk) and drops into the XPS base system beside the existing opb_register_* cores.

---
 rtl/opb_register_ppc2simulink_strobe.sv | 167 ++++++++++++++++
 tb/tb_opb_register_ppc2simulink_strobe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_ppc2simulink_strobe.sv
// OPB slave register written by the PowerPC and handed to fabric logic with a
// one-cycle update strobe; word 4 exposes a 16-bit write counter for readback.
module opb_register_ppc2simulink_strobe #(
  parameter logic [31:0] C_BASEADDR    = 32'h0100_0100,
  parameter logic [31:0] C_HIGHADDR    = 32'h0100_01FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000,
  parameter logic [63:0] C_FAMILY      = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  output logic [31:0]             user_data_out,
  output logic                    user_data_valid
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Bus vectors re-expressed little-endian: bit 0 of OPB lands on bit 31 here.
  logic [31:0] addr_s, wdata_s, offset_s;
  logic [3:0]  be_s;
  logic        hit_s, word0_s, word4_s;
  logic        unused_s;

  assign addr_s   = OPB_ABus;
  assign wdata_s  = OPB_DBus;
  assign be_s     = OPB_BE;
  assign offset_s = addr_s - C_BASEADDR;
  assign hit_s    = OPB_select && (addr_s >= C_BASEADDR) && (addr_s <= C_HIGHADDR);
  assign word0_s  = (offset_s[31:3] == 29'd0) && !addr_s[2];
  assign word4_s  = (offset_s[31:3] == 29'd0) && addr_s[2];
  assign unused_s = ^{OPB_seqAddr, C_FAMILY, offset_s[1:0]};

  logic [1:0]  state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rnw_q, rnw_d;
  logic        w0_q, w0_d;
  logic        w4_q, w4_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] user_q, user_d;
  logic        valid_q, valid_d;
  logic [15:0] write_count_q, write_count_d;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be_v);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be_v[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Transfer sequencing, read-data capture and write commit.
  always_comb begin
    state_d       = state_q;
    ack_d         = 1'b0;
    rdata_d       = 32'd0;
    rnw_d         = rnw_q;
    w0_d          = w0_q;
    w4_d          = w4_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    user_d        = user_q;
    valid_d       = 1'b0;
    write_count_d = write_count_q;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          rnw_d   = OPB_RNW;
          w0_d    = word0_s;
          w4_d    = word4_s;
          be_d    = be_s;
          wdata_d = wdata_s;
          if (OPB_RNW && word0_s) begin
            rdata_d = user_q;
          end else if (OPB_RNW && word4_s) begin
            rdata_d = {16'd0, write_count_q};
          end else begin
            rdata_d = 32'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d = ST_HOLD;
        if (!rnw_q && w0_q) begin
          user_d        = byte_merge(user_q, wdata_q, be_q);
          valid_d       = 1'b1;
          write_count_d = write_count_q + 16'd1;
        end else if (!rnw_q && w4_q) begin
          write_count_d = 16'd0;
        end else begin
          write_count_d = write_count_q;
        end
      end
      // Dead cycle so a late select deassertion is not decoded as a new hit.
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q       <= ST_IDLE;
      ack_q         <= 1'b0;
      rdata_q       <= 32'd0;
      rnw_q         <= 1'b1;
      w0_q          <= 1'b0;
      w4_q          <= 1'b0;
      be_q          <= 4'd0;
      wdata_q       <= 32'd0;
      user_q        <= C_RESET_VALUE;
      valid_q       <= 1'b0;
      write_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
      rnw_q         <= rnw_d;
      w0_q          <= w0_d;
      w4_q          <= w4_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      user_q        <= user_d;
      valid_q       <= valid_d;
      write_count_q <= write_count_d;
    end
  end

  assign Sl_DBus         = rdata_q;
  assign Sl_xferAck      = ack_q;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = user_q;
  assign user_data_valid = valid_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink_strobe.sv
// Randomized bench for opb_register_ppc2simulink_strobe with a transaction-level
// model of the register, counter and OPB handshake.
module tb_opb_register_ppc2simulink_strobe;

  localparam logic [31:0] BASE  = 32'h0100_0100;
  localparam logic [31:0] HIGH  = 32'h0100_01FF;
  localparam logic [31:0] RSTV  = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] abus = 32'd0;
  logic [0:3]  be = 4'd0;
  logic [0:31] dbus = 32'd0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        sl_err, sl_retry, sl_tout, sl_ack;
  logic [31:0] udata;
  logic        uvalid;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;
  int valid_cnt = 0;
  int leak_cnt = 0;

  logic [31:0] exp_reg;
  logic [15:0] exp_count;

  opb_register_ppc2simulink_strobe #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_RESET_VALUE(RSTV), .C_FAMILY("virtex5")
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
    .Sl_errAck(sl_err), .Sl_retry(sl_retry), .Sl_toutSup(sl_tout), .Sl_xferAck(sl_ack),
    .user_data_out(udata), .user_data_valid(uvalid)
  );

  always #5 clk = ~clk;

  // Observe outputs mid-cycle: count acks and strobes, flag bus or tie-off violations.
  always @(negedge clk) begin
    if (sl_ack === 1'b1) ack_cnt++;
    if (uvalid === 1'b1) valid_cnt++;
    if (sl_ack !== 1'b1 && sl_dbus !== 32'd0) leak_cnt++;
    if ({sl_err, sl_retry, sl_tout} !== 3'b000) leak_cnt++;
  end

  // One master transfer: select held until ack plus one cycle, then released.
  task automatic xfer(input logic [31:0] a, input logic r, input logic [3:0] b,
                      input logic [31:0] d, output logic acked,
                      output logic [31:0] rd, output int lat);
    @(negedge clk);
    abus = a; be = b; dbus = d; rnw = r; sel = 1'b1;
    acked = 1'b0; rd = 32'd0; lat = 0;
    for (int c = 1; c <= 8 && !acked; c++) begin
      @(negedge clk);
      if (sl_ack === 1'b1) begin
        acked = 1'b1; rd = sl_dbus; lat = c;
      end
    end
    if (acked) @(negedge clk);
    sel = 1'b0; abus = 32'd0; dbus = 32'd0; be = 4'd0; rnw = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] old_v,
                                              input logic [31:0] d, input logic [3:0] b);
    logic [31:0] res;
    logic [0:3]  bb;
    res = old_v;
    bb = b;
    for (int i = 0; i < 4; i++)
      if (bb[i]) res[31-8*i -: 8] = d[31-8*i -: 8];
    return res;
  endfunction

  // Applies the register rules to one transfer and checks ack, latency, data and strobe.
  task automatic model_xfer(input string tag, input logic [31:0] a, input logic r,
                            input logic [3:0] b, input logic [31:0] d);
    logic        acked, exp_ack;
    logic [31:0] rd, exp_rd, off;
    int          lat, a0, v0, exp_v;
    exp_ack = (a >= BASE) && (a <= HIGH);
    off = a - BASE;
    exp_rd = 32'd0;
    exp_v = 0;
    a0 = ack_cnt; v0 = valid_cnt;
    if (exp_ack && r) begin
      if (off < 32'd4) exp_rd = exp_reg;
      else if (off < 32'd8) exp_rd = {16'd0, exp_count};
      else exp_rd = 32'd0;
    end
    xfer(a, r, b, d, acked, rd, lat);
    if (exp_ack && !r) begin
      if (off < 32'd4) begin
        exp_reg = model_merge(exp_reg, d, b);
        exp_count = exp_count + 16'd1;
        exp_v = 1;
      end else if (off < 32'd8) begin
        exp_count = 16'd0;
      end
    end
    n_cmp++;
    if (acked !== exp_ack || ack_cnt - a0 !== (exp_ack ? 1 : 0) || (exp_ack && lat != 1)) begin
      n_bad++;
      $display("FAIL %s ack: acked=%0b pulses=%0d lat=%0d, required acked=%0b pulses=%0d lat=1",
               tag, acked, ack_cnt - a0, lat, exp_ack, exp_ack ? 1 : 0);
    end
    n_cmp++;
    if (rd !== exp_rd) begin
      n_bad++;
      $display("FAIL %s rdata: got %08h required %08h", tag, rd, exp_rd);
    end
    n_cmp++;
    if (udata !== exp_reg || valid_cnt - v0 !== exp_v) begin
      n_bad++;
      $display("FAIL %s reg/strobe: got %08h/%0d required %08h/%0d", tag, udata,
               valid_cnt - v0, exp_reg, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (udata !== RSTV || sl_ack !== 1'b0 || sl_dbus !== 32'd0 || uvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: data=%08h ack=%0b dbus=%08h valid=%0b required %08h/0/0/0",
               udata, sl_ack, sl_dbus, uvalid, RSTV);
    end
    rst = 1'b0;
    exp_reg = RSTV; exp_count = 16'd0;
    model_xfer("reset_count", BASE + 32'd4, 1'b1, 4'hF, 32'd0);
    model_xfer("reset_word0", BASE, 1'b1, 4'hF, 32'd0);
  endtask

  task automatic test_full_write();
    model_xfer("full_write", BASE, 1'b0, 4'b1111, 32'hDEAD_BEEF);
    n_cmp++;
    if (udata !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL full_value: got %08h required deadbeef", udata);
    end
    model_xfer("full_count", BASE + 32'd4, 1'b1, 4'hF, 32'd0);
  endtask

  task automatic test_partial_write();
    model_xfer("partial_write", BASE, 1'b0, 4'b0101, 32'h1122_3344);
    n_cmp++;
    if (udata !== 32'hDE22_BE44) begin
      n_bad++;
      $display("FAIL partial_value: got %08h required de22be44", udata);
    end
    model_xfer("partial_read", BASE, 1'b1, 4'b1111, 32'd0);
  endtask

  task automatic test_out_of_window();
    model_xfer("oow_write", HIGH + 32'd4, 1'b0, 4'hF, 32'h0000_0055);
    model_xfer("oow_below", BASE - 32'd4, 1'b0, 4'hF, 32'h0000_0055);
    model_xfer("oow_count", BASE + 32'd4, 1'b1, 4'hF, 32'd0);
    model_xfer("high_edge", HIGH, 1'b0, 4'hF, 32'h0000_0066);
    model_xfer("high_read", HIGH - 32'd3, 1'b1, 4'hF, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1: a = BASE + $urandom_range(0, 3);
        2: a = BASE + 32'd4 + $urandom_range(0, 3);
        3: a = BASE + 32'd8 + $urandom_range(0, 247);
        default: a = ($urandom_range(0, 1) == 0) ? HIGH + 32'd1 + $urandom_range(0, 255)
                                                 : BASE - 32'd1 - $urandom_range(0, 255);
      endcase
      model_xfer("random", a, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), $urandom);
    end
    model_xfer("random_count", BASE + 32'd4, 1'b1, 4'hF, 32'd0);
  endtask

  task automatic test_back_to_back();
    int a0, v0;
    logic [31:0] d;
    d = $urandom;
    a0 = ack_cnt; v0 = valid_cnt;
    @(negedge clk);
    abus = BASE; be = 4'hF; dbus = d; rnw = 1'b0; sel = 1'b1;
    repeat (12) @(negedge clk);
    sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_reg = d;
    exp_count = exp_count + 16'd4;
    n_cmp++;
    if (ack_cnt - a0 != 4 || valid_cnt - v0 != 4 || udata !== exp_reg) begin
      n_bad++;
      $display("FAIL back_to_back: acks=%0d strobes=%0d data=%08h required 4/4/%08h",
               ack_cnt - a0, valid_cnt - v0, udata, exp_reg);
    end
    model_xfer("b2b_count", BASE + 32'd4, 1'b1, 4'hF, 32'd0);
  endtask

  task automatic test_count_wrap();
    // Jump the counter close to the wrap point instead of issuing 65534 writes.
    @(negedge clk);
    force dut.write_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.write_count_q;
    exp_count = 16'hFFFE;
    model_xfer("wrap_pre", BASE + 32'd4, 1'b1, 4'hF, 32'd0);
    model_xfer("wrap_w1", BASE, 1'b0, 4'hF, $urandom);
    model_xfer("wrap_w2", BASE, 1'b0, 4'hF, $urandom);
    model_xfer("wrap_zero", BASE + 32'd4, 1'b1, 4'hF, 32'd0);
    model_xfer("wrap_w3", BASE, 1'b0, 4'h0, $urandom);
    model_xfer("wrap_one", BASE + 32'd4, 1'b1, 4'hF, 32'd0);
    model_xfer("clear", BASE + 32'd4, 1'b0, 4'h0, $urandom);
    model_xfer("clear_read", BASE + 32'd4, 1'b1, 4'hF, 32'd0);
  endtask

  task automatic test_reset_mid_transfer();
    int v0;
    v0 = valid_cnt;
    @(negedge clk);
    abus = BASE; be = 4'hF; dbus = 32'hCAFE_F00D; rnw = 1'b0; sel = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sl_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_ack_before: got %0b required 1", sl_ack);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (sl_ack !== 1'b0 || udata !== RSTV) begin
      n_bad++;
      $display("FAIL midrst_abort: ack=%0b data=%08h required 0/%08h", sl_ack, udata, RSTV);
    end
    @(negedge clk);
    sel = 1'b0; dbus = 32'd0;
    rst = 1'b0;
    exp_reg = RSTV; exp_count = 16'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (valid_cnt != v0 || udata !== RSTV) begin
      n_bad++;
      $display("FAIL midrst_commit: strobes=%0d data=%08h required 0/%08h",
               valid_cnt - v0, udata, RSTV);
    end
    model_xfer("midrst_count", BASE + 32'd4, 1'b1, 4'hF, 32'd0);
  endtask

  task automatic test_bus_idle();
    n_cmp++;
    if (leak_cnt != 0) begin
      n_bad++;
      $display("FAIL bus_idle: %0d cycles with nonzero Sl_DBus or tie-offs, required 0", leak_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_partial_write();
    test_out_of_window();
    test_random();
    test_back_to_back();
    test_count_wrap();
    test_reset_mid_transfer();
    test_bus_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
